// File: rtl/arashi_thread_arbiter.sv
// ============================================================================
// Module   : arashi_thread_arbiter
// Purpose  : Round-robin read scheduler feeding tagged cache words into a
//            4-entry credit-protected output FIFO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module arashi_thread_arbiter #(
    parameter int NUM_THREADS = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int TID_WIDTH   = (NUM_THREADS > 2) ? $clog2(NUM_THREADS) : 1
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              enable,
    input  logic [NUM_THREADS-1:0]            avail,
    input  logic [NUM_THREADS*DATA_WIDTH-1:0] cache_data,
    output logic [NUM_THREADS-1:0]            r_ena,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [DATA_WIDTH-1:0]             out_data,
    output logic [TID_WIDTH-1:0]              out_tid
);

    localparam int C_FIFO_DEPTH = 4;

    logic [TID_WIDTH-1:0]  r_rr_ptr;
    logic                  r_s1_valid;
    logic [TID_WIDTH-1:0]  r_s1_tag;
    logic                  r_s2_valid;
    logic [TID_WIDTH-1:0]  r_s2_tag;
    logic [DATA_WIDTH-1:0] r_mem_data [C_FIFO_DEPTH];
    logic [TID_WIDTH-1:0]  r_mem_tid  [C_FIFO_DEPTH];
    logic [1:0]            r_wr_ptr;
    logic [1:0]            r_rd_ptr;
    logic [2:0]            r_count;

    logic [NUM_THREADS-1:0] w_elig;
    logic                   w_found;
    logic [TID_WIDTH-1:0]   w_winner;
    logic [TID_WIDTH-1:0]   w_next_ptr;
    int                     w_idx;
    logic [3:0]             w_commit;
    logic                   w_credit_ok;
    logic                   w_grant;
    logic                   w_push;
    logic                   w_pop;
    logic [DATA_WIDTH-1:0]  w_capture;

    assign w_elig = avail & {NUM_THREADS{enable}};

    // First eligible index at or after the pointer, wrapping modulo NUM_THREADS.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = 0;
        for (int i = 0; i < NUM_THREADS; i++) begin
            w_idx = int'(r_rr_ptr) + i;
            if (w_idx >= NUM_THREADS) begin
                w_idx = w_idx - NUM_THREADS;
            end
            if (!w_found && w_elig[w_idx]) begin
                w_found  = 1'b1;
                w_winner = TID_WIDTH'(w_idx);
            end
        end
    end

    assign w_next_ptr = (w_winner == TID_WIDTH'(NUM_THREADS - 1)) ? '0 : w_winner + 1'b1;

    // Reserve a FIFO slot for every outstanding read; a same-edge pop earns no credit.
    assign w_commit    = {1'b0, r_count} + {3'b000, r_s1_valid} + {3'b000, r_s2_valid} + 4'd1;
    assign w_credit_ok = (w_commit <= 4'd4);
    assign w_grant     = w_found && w_credit_ok;

    assign out_valid = (r_count != 3'd0);
    assign w_pop     = out_valid && out_ready;
    assign w_push    = r_s2_valid;
    assign w_capture = cache_data[int'(r_s2_tag) * DATA_WIDTH +: DATA_WIDTH];

    assign out_data = out_valid ? r_mem_data[r_rd_ptr] : '0;
    assign out_tid  = out_valid ? r_mem_tid[r_rd_ptr]  : '0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ena      <= '0;
            r_rr_ptr   <= '0;
            r_s1_valid <= 1'b0;
            r_s1_tag   <= '0;
            r_s2_valid <= 1'b0;
            r_s2_tag   <= '0;
        end else begin
            r_ena      <= w_grant ? (NUM_THREADS'(1) << w_winner) : '0;
            r_s1_valid <= w_grant;
            r_s1_tag   <= w_winner;
            r_s2_valid <= r_s1_valid;
            r_s2_tag   <= r_s1_tag;
            if (w_grant) begin
                r_rr_ptr <= w_next_ptr;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 2'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 3'd1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 3'd1;
            end
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= w_capture;
            r_mem_tid[r_wr_ptr]  <= r_s2_tag;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_arashi_thread_arbiter.sv
// ============================================================================
// Module   : tb_arashi_thread_arbiter
// Purpose  : Directed self-checking bench for the round-robin thread arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_arashi_thread_arbiter;

    localparam int NT = 4;
    localparam int DW = 32;
    localparam int TW = 2;

    logic              clk;
    logic              rstn;
    logic              enable;
    logic [NT-1:0]     avail;
    logic [NT*DW-1:0]  cache_data;
    logic [NT-1:0]     r_ena;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_data;
    logic [TW-1:0]     out_tid;

    logic [DW-1:0]     cache_word [NT];
    logic [DW-1:0]     cache_q    [NT];

    int n_cmp  = 0;
    int n_fail = 0;

    arashi_thread_arbiter #(
        .NUM_THREADS(NT),
        .DATA_WIDTH (DW),
        .TID_WIDTH  (TW)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .enable    (enable),
        .avail     (avail),
        .cache_data(cache_data),
        .r_ena     (r_ena),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tid   (out_tid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cache model: registers its word when read-enabled, otherwise outputs 0.
    always @(posedge clk) begin
        for (int i = 0; i < NT; i++) begin
            cache_q[i] <= r_ena[i] ? cache_word[i] : '0;
        end
    end

    always_comb begin
        cache_data = '0;
        for (int i = 0; i < NT; i++) begin
            cache_data[i*DW +: DW] = cache_q[i];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn      = 1'b0;
        enable    = 1'b0;
        avail     = '0;
        out_ready = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({r_ena, out_valid, out_data, out_tid} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got r_ena=%b valid=%b data=%h tid=%0d, want all 0",
                     r_ena, out_valid, out_data, out_tid);
        end
    endtask

    task automatic test_single_thread();
        do_reset();
        enable = 1'b1;
        avail  = 4'b0100;
        tick();
        avail = '0;
        n_cmp++;
        if (r_ena !== 4'b0100) begin
            n_fail++;
            $display("FAIL single_grant: r_ena=%b want 0100", r_ena);
        end
        tick();
        n_cmp++;
        if (r_ena !== 4'b0000 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_e1: r_ena=%b valid=%b want 0000/0", r_ena, out_valid);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 32'hA5A5_A5A5 || out_tid !== 2'd2) begin
            n_fail++;
            $display("FAIL single_out: valid=%b data=%h tid=%0d want 1/a5a5a5a5/2",
                     out_valid, out_data, out_tid);
        end
        out_ready = 1'b1;
        tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_pop: valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [NT-1:0] exp_ena;
        logic [TW-1:0] exp_tid;
        do_reset();
        enable    = 1'b1;
        out_ready = 1'b1;
        avail     = 4'b1111;
        for (int k = 0; k < 12; k++) begin
            tick();
            exp_ena = 4'b0001 << (k % 4);
            n_cmp++;
            if (r_ena !== exp_ena) begin
                n_fail++;
                $display("FAIL rr_grant[%0d]: r_ena=%b want %b", k, r_ena, exp_ena);
            end
            if (k >= 2) begin
                exp_tid = TW'((k - 2) % 4);
                n_cmp++;
                if (out_valid !== 1'b1 || out_tid !== exp_tid || out_data !== cache_word[exp_tid]) begin
                    n_fail++;
                    $display("FAIL rr_out[%0d]: valid=%b tid=%0d data=%h want 1/%0d/%h",
                             k, out_valid, out_tid, out_data, exp_tid, cache_word[exp_tid]);
                end
            end
        end
    endtask

    task automatic test_fairness_skip();
        logic [NT-1:0] exp_ena;
        do_reset();
        enable    = 1'b1;
        out_ready = 1'b1;
        avail     = 4'b1001;
        for (int k = 0; k < 8; k++) begin
            tick();
            exp_ena = (k % 2 == 0) ? 4'b0001 : 4'b1000;
            n_cmp++;
            if (r_ena !== exp_ena) begin
                n_fail++;
                $display("FAIL skip_grant[%0d]: r_ena=%b want %b", k, r_ena, exp_ena);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [NT-1:0] exp_ena  [12];
        logic [TW-1:0] exp_head [12];
        logic          exp_vld  [12];
        // Hand-derived from the credit rule: 4 grants, stall, drain, resume from thread 0.
        exp_ena  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000,
                     4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b0000};
        exp_vld  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        exp_head = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        enable = 1'b1;
        avail  = 4'b1111;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (k == 7) begin
                out_ready = 1'b1;
            end
            if (k == 10) begin
                avail = '0;
            end
            n_cmp++;
            if (r_ena !== exp_ena[k] || out_valid !== exp_vld[k] ||
                (exp_vld[k] && out_tid !== exp_head[k])) begin
                n_fail++;
                $display("FAIL bp[%0d]: r_ena=%b valid=%b tid=%0d want %b/%b/%0d",
                         k, r_ena, out_valid, out_tid, exp_ena[k], exp_vld[k], exp_head[k]);
            end
        end
    endtask

    task automatic test_enable_drop();
        do_reset();
        enable    = 1'b1;
        out_ready = 1'b1;
        avail     = 4'b1111;
        tick();
        enable = 1'b0;
        n_cmp++;
        if (r_ena !== 4'b0001) begin
            n_fail++;
            $display("FAIL en_first: r_ena=%b want 0001", r_ena);
        end
        tick();
        n_cmp++;
        if (r_ena !== 4'b0000) begin
            n_fail++;
            $display("FAIL en_suppress: r_ena=%b want 0000", r_ena);
        end
        tick();
        n_cmp++;
        if (r_ena !== 4'b0000 || out_valid !== 1'b1 || out_tid !== 2'd0 || out_data !== cache_word[0]) begin
            n_fail++;
            $display("FAIL en_inflight: r_ena=%b valid=%b tid=%0d data=%h want 0000/1/0/%h",
                     r_ena, out_valid, out_tid, out_data, cache_word[0]);
        end
        tick();
        enable = 1'b1;
        n_cmp++;
        if (r_ena !== 4'b0000 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL en_idle: r_ena=%b valid=%b want 0000/0", r_ena, out_valid);
        end
        tick();
        n_cmp++;
        if (r_ena !== 4'b0010) begin
            n_fail++;
            $display("FAIL en_resume: r_ena=%b want 0010", r_ena);
        end
    endtask

    task automatic test_reset_midop();
        do_reset();
        enable = 1'b1;
        avail  = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            tick();
        end
        n_cmp++;
        if (r_ena !== 4'b1000 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL midop_setup: r_ena=%b valid=%b want 1000/1", r_ena, out_valid);
        end
        #2;
        rstn = 1'b0;
        #1;
        n_cmp++;
        if ({r_ena, out_valid, out_data, out_tid} !== '0) begin
            n_fail++;
            $display("FAIL midop_async: r_ena=%b valid=%b data=%h tid=%0d want all 0",
                     r_ena, out_valid, out_data, out_tid);
        end
        #1;
        rstn      = 1'b1;
        out_ready = 1'b1;
        tick();
        n_cmp++;
        if (r_ena !== 4'b0001 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midop_first: r_ena=%b valid=%b want 0001/0", r_ena, out_valid);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midop_stale: valid=%b want 0", out_valid);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_tid !== 2'd0 || out_data !== cache_word[0]) begin
            n_fail++;
            $display("FAIL midop_out: valid=%b tid=%0d data=%h want 1/0/%h",
                     out_valid, out_tid, out_data, cache_word[0]);
        end
    endtask

    initial begin
        cache_word[0] = 32'hC0DE_0000;
        cache_word[1] = 32'hC0DE_0001;
        cache_word[2] = 32'hA5A5_A5A5;
        cache_word[3] = 32'hC0DE_0003;
        rstn      = 1'b0;
        enable    = 1'b0;
        avail     = '0;
        out_ready = 1'b0;
        test_reset();
        test_single_thread();
        test_round_robin();
        test_fairness_skip();
        test_backpressure();
        test_enable_drop();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
